// File: rtl/vram_access_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_access_responder_if
// Brief    : Arbiter / external VRAM / read-toggle bundle for the VRAM responder.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_access_responder_if;
    logic [1:0]  DOTSTATE;
    logic [18:0] IRAMADR;
    logic [7:0]  PRAMDBO_8;
    logic        PRAMWE_N;
    logic        VDPVRAMREADINGR;
    logic        vdp_cmd_vram_reading_req;
    logic [7:0]  mem_rdata;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we_n;
    logic        mem_oe_n;
    logic [7:0]  PRAMDBI_8;
    logic        pramdbi_vld;
    logic        VDPVRAMREADINGA;
    logic [7:0]  VDPVRAMRDDATA;
    logic        vdp_cmd_vram_reading_ack;
    logic [7:0]  vdp_cmd_vram_rd_data;

    modport slave (
        input  DOTSTATE, IRAMADR, PRAMDBO_8, PRAMWE_N,
        input  VDPVRAMREADINGR, vdp_cmd_vram_reading_req, mem_rdata,
        output mem_addr, mem_wdata, mem_we_n, mem_oe_n,
        output PRAMDBI_8, pramdbi_vld,
        output VDPVRAMREADINGA, VDPVRAMRDDATA,
        output vdp_cmd_vram_reading_ack, vdp_cmd_vram_rd_data
    );

    modport master (
        output DOTSTATE, IRAMADR, PRAMDBO_8, PRAMWE_N,
        output VDPVRAMREADINGR, vdp_cmd_vram_reading_req, mem_rdata,
        input  mem_addr, mem_wdata, mem_we_n, mem_oe_n,
        input  PRAMDBI_8, pramdbi_vld,
        input  VDPVRAMREADINGA, VDPVRAMRDDATA,
        input  vdp_cmd_vram_reading_ack, vdp_cmd_vram_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/vram_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : vram_access_responder
// Brief    : Dot-phase slotted external VRAM access with CPU/command read toggles.
// Revision : 1.0 - initial release
// ============================================================================
module vram_access_responder (
    input  wire logic                     CLK21M,
    input  wire logic                     RESET,
    vram_access_responder_if.slave        bus
);

    localparam logic [1:0] c_dot_pri = 2'b00;
    localparam logic [1:0] c_dot_sec = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRI_ACC = 2'd1,
        ST_SEC_ACC = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_launch_pri;
    logic        w_launch_sec;
    logic        w_cap_pri;
    logic        w_cap_sec;
    logic        w_pri_write;
    logic        w_cpu_pend;
    logic        w_cmd_pend;

    logic [18:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_we_n;
    logic        r_mem_oe_n;
    logic [7:0]  r_pramdbi;
    logic        r_pramdbi_vld;
    logic        r_cpu_ack;
    logic [7:0]  r_cpu_rdata;
    logic        r_cmd_ack;
    logic [7:0]  r_cmd_rdata;
    logic        r_wr;
    logic        r_cpu_tag;
    logic        r_cmd_tag;
    logic        r_cpu_req_lat;
    logic        r_cmd_req_lat;

    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Launch only from IDLE; the cycle that leaves an ACC state is the capture cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_launch_pri = 1'b0;
        w_launch_sec = 1'b0;
        w_cap_pri    = 1'b0;
        w_cap_sec    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.DOTSTATE == c_dot_pri) begin
                    w_state_nxt  = ST_PRI_ACC;
                    w_launch_pri = 1'b1;
                end else if (bus.DOTSTATE == c_dot_sec) begin
                    w_state_nxt  = ST_SEC_ACC;
                    w_launch_sec = 1'b1;
                end
            end
            ST_PRI_ACC: begin
                w_state_nxt = ST_IDLE;
                w_cap_pri   = ~r_wr;
            end
            ST_SEC_ACC: begin
                w_state_nxt = ST_IDLE;
                w_cap_sec   = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pri_write = w_launch_pri & ~bus.PRAMWE_N;
    assign w_cpu_pend  = bus.VDPVRAMREADINGR != r_cpu_ack;
    assign w_cmd_pend  = bus.vdp_cmd_vram_reading_req != r_cmd_ack;

    always_ff @(posedge CLK21M or posedge RESET) begin
        if (RESET) begin
            r_mem_addr    <= 19'h7FFFF;
            r_mem_wdata   <= 8'h00;
            r_mem_we_n    <= 1'b1;
            r_mem_oe_n    <= 1'b1;
            r_pramdbi     <= 8'h00;
            r_pramdbi_vld <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_cpu_rdata   <= 8'h00;
            r_cmd_ack     <= 1'b0;
            r_cmd_rdata   <= 8'h00;
            r_wr          <= 1'b0;
            r_cpu_tag     <= 1'b0;
            r_cmd_tag     <= 1'b0;
            r_cpu_req_lat <= 1'b0;
            r_cmd_req_lat <= 1'b0;
        end else begin
            r_mem_we_n    <= 1'b1;
            r_mem_oe_n    <= 1'b1;
            r_pramdbi_vld <= 1'b0;

            if (w_launch_pri || w_launch_sec) begin
                r_mem_addr <= bus.IRAMADR;
                r_wr       <= w_pri_write;
                if (w_pri_write) begin
                    r_mem_wdata <= bus.PRAMDBO_8;
                    r_mem_we_n  <= 1'b0;
                end else begin
                    r_mem_oe_n  <= 1'b0;
                end
            end

            // Request levels are frozen here so a toggle during the access waits a slot.
            if (w_launch_pri && !w_pri_write) begin
                r_cpu_tag     <= w_cpu_pend;
                r_cmd_tag     <= w_cmd_pend & ~w_cpu_pend;
                r_cpu_req_lat <= bus.VDPVRAMREADINGR;
                r_cmd_req_lat <= bus.vdp_cmd_vram_reading_req;
            end

            if (w_cap_pri || w_cap_sec) begin
                r_pramdbi     <= bus.mem_rdata;
                r_pramdbi_vld <= 1'b1;
            end

            if (w_cap_pri) begin
                if (r_cpu_tag) begin
                    r_cpu_rdata <= bus.mem_rdata;
                    r_cpu_ack   <= r_cpu_req_lat;
                end
                if (r_cmd_tag) begin
                    r_cmd_rdata <= bus.mem_rdata;
                    r_cmd_ack   <= r_cmd_req_lat;
                end
                r_cpu_tag <= 1'b0;
                r_cmd_tag <= 1'b0;
            end
        end
    end

    assign bus.mem_addr                 = r_mem_addr;
    assign bus.mem_wdata                = r_mem_wdata;
    assign bus.mem_we_n                 = r_mem_we_n;
    assign bus.mem_oe_n                 = r_mem_oe_n;
    assign bus.PRAMDBI_8                = r_pramdbi;
    assign bus.pramdbi_vld              = r_pramdbi_vld;
    assign bus.VDPVRAMREADINGA          = r_cpu_ack;
    assign bus.VDPVRAMRDDATA            = r_cpu_rdata;
    assign bus.vdp_cmd_vram_reading_ack = r_cmd_ack;
    assign bus.vdp_cmd_vram_rd_data     = r_cmd_rdata;

endmodule
`default_nettype wire

// File: tb/tb_vram_access_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_access_responder
// Brief    : Self-checking bench for vram_access_responder, directed and random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_access_responder;

    logic CLK21M = 1'b0;
    logic RESET  = 1'b0;
    always #5 CLK21M = ~CLK21M;

    vram_access_responder_if bus ();

    vram_access_responder dut (
        .CLK21M (CLK21M),
        .RESET  (RESET),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Observations of one dot cycle: L=primary launch, C=primary capture,
    // S=secondary launch, T=secondary capture.
    logic [18:0] o_l_addr, o_c_addr, o_s_addr;
    logic [7:0]  o_l_wdata, o_c_dbi, o_c_cpu_data, o_c_cmd_data, o_t_dbi;
    logic        o_l_we, o_l_oe, o_c_we, o_c_oe, o_c_vld, o_c_cpu_ack, o_c_cmd_ack;
    logic        o_s_we, o_s_oe, o_t_vld, o_t_cpu_ack, o_t_cmd_ack;

    function automatic logic [1:0] dot_next(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK21M);
        #1;
        bus.DOTSTATE = dot_next(bus.DOTSTATE);
    endtask

    task automatic align();
        for (int i = 0; i < 4 && bus.DOTSTATE != 2'b00; i++) tick();
    endtask

    // One full dot cycle starting with DOTSTATE==00 visible.
    task automatic do_dot(input logic we_n, input logic [18:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rd_pri, input logic late_cpu, input logic late_cmd,
                          input logic sec_we_n, input logic [18:0] sec_addr, input logic [7:0] rd_sec);
        bus.IRAMADR   = addr;
        bus.PRAMWE_N  = we_n;
        bus.PRAMDBO_8 = we_n ? 8'hzz : wdata;
        bus.mem_rdata = 8'($urandom);
        tick();
        o_l_addr = bus.mem_addr; o_l_wdata = bus.mem_wdata;
        o_l_we = bus.mem_we_n;   o_l_oe = bus.mem_oe_n;
        bus.mem_rdata = rd_pri;
        bus.IRAMADR   = 19'($urandom);
        bus.PRAMWE_N  = 1'($urandom);
        bus.PRAMDBO_8 = 8'($urandom);
        if (late_cpu) bus.VDPVRAMREADINGR = ~bus.VDPVRAMREADINGR;
        if (late_cmd) bus.vdp_cmd_vram_reading_req = ~bus.vdp_cmd_vram_reading_req;
        tick();
        o_c_addr = bus.mem_addr; o_c_we = bus.mem_we_n; o_c_oe = bus.mem_oe_n;
        o_c_vld = bus.pramdbi_vld; o_c_dbi = bus.PRAMDBI_8;
        o_c_cpu_ack = bus.VDPVRAMREADINGA; o_c_cpu_data = bus.VDPVRAMRDDATA;
        o_c_cmd_ack = bus.vdp_cmd_vram_reading_ack; o_c_cmd_data = bus.vdp_cmd_vram_rd_data;
        bus.mem_rdata = 8'($urandom);
        bus.IRAMADR   = sec_addr;
        bus.PRAMWE_N  = sec_we_n;
        tick();
        o_s_addr = bus.mem_addr; o_s_we = bus.mem_we_n; o_s_oe = bus.mem_oe_n;
        bus.mem_rdata = rd_sec;
        bus.IRAMADR   = 19'($urandom);
        tick();
        o_t_vld = bus.pramdbi_vld; o_t_dbi = bus.PRAMDBI_8;
        o_t_cpu_ack = bus.VDPVRAMREADINGA; o_t_cmd_ack = bus.vdp_cmd_vram_reading_ack;
        bus.mem_rdata = 8'($urandom);
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        #1;
        n_chk++; if (bus.mem_addr !== 19'h7FFFF) $display("FAIL rst_addr: got %h want 7ffff", bus.mem_addr); else n_pass++;
        n_chk++; if (bus.mem_wdata !== 8'h00) $display("FAIL rst_wdata: got %h want 00", bus.mem_wdata); else n_pass++;
        n_chk++; if (bus.mem_we_n !== 1'b1) $display("FAIL rst_we_n: got %b want 1", bus.mem_we_n); else n_pass++;
        n_chk++; if (bus.mem_oe_n !== 1'b1) $display("FAIL rst_oe_n: got %b want 1", bus.mem_oe_n); else n_pass++;
        n_chk++; if (bus.PRAMDBI_8 !== 8'h00) $display("FAIL rst_dbi: got %h want 00", bus.PRAMDBI_8); else n_pass++;
        n_chk++; if (bus.pramdbi_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", bus.pramdbi_vld); else n_pass++;
        n_chk++; if (bus.VDPVRAMRDDATA !== 8'h00) $display("FAIL rst_cpu_data: got %h want 00", bus.VDPVRAMRDDATA); else n_pass++;
        n_chk++; if (bus.vdp_cmd_vram_rd_data !== 8'h00) $display("FAIL rst_cmd_data: got %h want 00", bus.vdp_cmd_vram_rd_data); else n_pass++;
        n_chk++; if (bus.VDPVRAMREADINGA !== 1'b0) $display("FAIL rst_cpu_ack: got %b want 0", bus.VDPVRAMREADINGA); else n_pass++;
        n_chk++; if (bus.vdp_cmd_vram_reading_ack !== 1'b0) $display("FAIL rst_cmd_ack: got %b want 0", bus.vdp_cmd_vram_reading_ack); else n_pass++;
        tick();
        tick();
        n_chk++; if (bus.mem_oe_n !== 1'b1) $display("FAIL rst_hold_oe_n: got %b want 1", bus.mem_oe_n); else n_pass++;
        RESET = 1'b0;
        align();
    endtask

    task automatic test_primary_write();
        bus.VDPVRAMREADINGR = 1'b1;
        do_dot(1'b0, 19'h12345, 8'hA5, 8'hEE, 1'b0, 1'b0, 1'b1, 19'h00001, 8'h5A);
        n_chk++; if (o_l_addr !== 19'h12345) $display("FAIL wr_addr: got %h want 12345", o_l_addr); else n_pass++;
        n_chk++; if (o_l_wdata !== 8'hA5) $display("FAIL wr_wdata: got %h want a5", o_l_wdata); else n_pass++;
        n_chk++; if (o_l_we !== 1'b0) $display("FAIL wr_we_pulse: got %b want 0", o_l_we); else n_pass++;
        n_chk++; if (o_l_oe !== 1'b1) $display("FAIL wr_oe: got %b want 1", o_l_oe); else n_pass++;
        n_chk++; if (o_c_we !== 1'b1) $display("FAIL wr_we_end: got %b want 1", o_c_we); else n_pass++;
        n_chk++; if (o_c_addr !== 19'h12345) $display("FAIL wr_addr_hold: got %h want 12345", o_c_addr); else n_pass++;
        n_chk++; if (o_c_vld !== 1'b0) $display("FAIL wr_no_vld: got %b want 0", o_c_vld); else n_pass++;
        n_chk++; if (o_c_cpu_ack !== 1'b0) $display("FAIL wr_no_ack: got %b want 0", o_c_cpu_ack); else n_pass++;
        n_chk++; if (o_t_cpu_ack !== 1'b0) $display("FAIL sec_no_ack: got %b want 0", o_t_cpu_ack); else n_pass++;
    endtask

    task automatic test_cpu_read();
        do_dot(1'b1, 19'h00400, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1, 19'h00402, 8'h81);
        n_chk++; if (o_l_addr !== 19'h00400) $display("FAIL rd_addr: got %h want 00400", o_l_addr); else n_pass++;
        n_chk++; if (o_l_oe !== 1'b0 || o_l_we !== 1'b1) $display("FAIL rd_strobes: got oe=%b we=%b want oe=0 we=1", o_l_oe, o_l_we); else n_pass++;
        n_chk++; if (o_c_cpu_data !== 8'h3C) $display("FAIL rd_cpu_data: got %h want 3c", o_c_cpu_data); else n_pass++;
        n_chk++; if (o_c_cpu_ack !== 1'b1) $display("FAIL rd_cpu_ack: got %b want 1", o_c_cpu_ack); else n_pass++;
        n_chk++; if (o_c_dbi !== 8'h3C || o_c_vld !== 1'b1) $display("FAIL rd_dbi: got %h/%b want 3c/1", o_c_dbi, o_c_vld); else n_pass++;
        n_chk++; if (o_c_oe !== 1'b1) $display("FAIL rd_oe_end: got %b want 1", o_c_oe); else n_pass++;
        n_chk++; if (o_c_cmd_ack !== 1'b0) $display("FAIL rd_cmd_ack: got %b want 0", o_c_cmd_ack); else n_pass++;
        n_chk++; if (o_t_dbi !== 8'h81) $display("FAIL rd_sec_dbi: got %h want 81", o_t_dbi); else n_pass++;
    endtask

    task automatic test_both_pending();
        bus.VDPVRAMREADINGR = 1'b0;
        bus.vdp_cmd_vram_reading_req = 1'b1;
        do_dot(1'b1, 19'h00500, 8'h00, 8'h11, 1'b0, 1'b0, 1'b1, 19'h00501, 8'h90);
        n_chk++; if (o_c_cpu_data !== 8'h11) $display("FAIL both1_cpu_data: got %h want 11", o_c_cpu_data); else n_pass++;
        n_chk++; if (o_c_cpu_ack !== 1'b0) $display("FAIL both1_cpu_ack: got %b want 0", o_c_cpu_ack); else n_pass++;
        n_chk++; if (o_c_cmd_ack !== 1'b0) $display("FAIL both1_cmd_ack: got %b want 0", o_c_cmd_ack); else n_pass++;
        do_dot(1'b1, 19'h00600, 8'h00, 8'h22, 1'b0, 1'b0, 1'b1, 19'h00601, 8'h91);
        n_chk++; if (o_c_cmd_data !== 8'h22) $display("FAIL both2_cmd_data: got %h want 22", o_c_cmd_data); else n_pass++;
        n_chk++; if (o_c_cmd_ack !== 1'b1) $display("FAIL both2_cmd_ack: got %b want 1", o_c_cmd_ack); else n_pass++;
        n_chk++; if (o_c_cpu_data !== 8'h11) $display("FAIL both2_cpu_data: got %h want 11", o_c_cpu_data); else n_pass++;
    endtask

    task automatic test_secondary();
        bus.VDPVRAMREADINGR = 1'b1;
        do_dot(1'b0, 19'h00010, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 19'h3ABCD, 8'h77);
        n_chk++; if (o_s_we !== 1'b1) $display("FAIL sec_we_n: got %b want 1", o_s_we); else n_pass++;
        n_chk++; if (o_s_oe !== 1'b0) $display("FAIL sec_oe_n: got %b want 0", o_s_oe); else n_pass++;
        n_chk++; if (o_s_addr !== 19'h3ABCD) $display("FAIL sec_addr: got %h want 3abcd", o_s_addr); else n_pass++;
        n_chk++; if (o_t_dbi !== 8'h77 || o_t_vld !== 1'b1) $display("FAIL sec_dbi: got %h/%b want 77/1", o_t_dbi, o_t_vld); else n_pass++;
        n_chk++; if (o_t_cpu_ack !== 1'b0 || o_t_cmd_ack !== 1'b1) $display("FAIL sec_acks: got %b/%b want 0/1", o_t_cpu_ack, o_t_cmd_ack); else n_pass++;
    endtask

    task automatic test_reset_abort();
        bus.IRAMADR   = 19'h00400;
        bus.PRAMWE_N  = 1'b1;
        bus.mem_rdata = 8'h99;
        tick();
        n_chk++; if (bus.mem_oe_n !== 1'b0) $display("FAIL abort_launch: got %b want 0", bus.mem_oe_n); else n_pass++;
        RESET = 1'b1;
        #1;
        n_chk++; if (bus.mem_oe_n !== 1'b1) $display("FAIL abort_oe_n: got %b want 1", bus.mem_oe_n); else n_pass++;
        tick();
        n_chk++; if (bus.VDPVRAMREADINGA !== 1'b0 || bus.pramdbi_vld !== 1'b0) $display("FAIL abort_no_ack: got %b/%b want 0/0", bus.VDPVRAMREADINGA, bus.pramdbi_vld); else n_pass++;
        RESET = 1'b0;
        tick();
        n_chk++; if (bus.mem_oe_n !== 1'b0) $display("FAIL abort_first_launch: got %b want 0", bus.mem_oe_n); else n_pass++;
        tick();
        n_chk++; if (bus.VDPVRAMREADINGA !== 1'b0) $display("FAIL abort_sec_ack: got %b want 0", bus.VDPVRAMREADINGA); else n_pass++;
        do_dot(1'b1, 19'h00400, 8'h00, 8'h4D, 1'b0, 1'b0, 1'b1, 19'h00401, 8'h02);
        n_chk++; if (o_c_cpu_ack !== 1'b1 || o_c_cpu_data !== 8'h4D) $display("FAIL abort_served: got %b/%h want 1/4d", o_c_cpu_ack, o_c_cpu_data); else n_pass++;
    endtask

    task automatic test_late_toggle();
        do_dot(1'b1, 19'h01000, 8'h00, 8'h61, 1'b1, 1'b0, 1'b1, 19'h01001, 8'h03);
        n_chk++; if (o_c_cpu_ack !== 1'b1 || o_c_cpu_data !== 8'h4D) $display("FAIL late_not_served: got %b/%h want 1/4d", o_c_cpu_ack, o_c_cpu_data); else n_pass++;
        do_dot(1'b1, 19'h01002, 8'h00, 8'h62, 1'b0, 1'b0, 1'b1, 19'h01003, 8'h04);
        n_chk++; if (o_c_cpu_ack !== 1'b0 || o_c_cpu_data !== 8'h62) $display("FAIL late_served: got %b/%h want 0/62", o_c_cpu_ack, o_c_cpu_data); else n_pass++;
    endtask

    task automatic test_random();
        logic       m_cpu_ack, m_cmd_ack;
        logic [7:0] m_cpu_data, m_cmd_data, m_dbi;
        RESET = 1'b1;
        bus.VDPVRAMREADINGR = 1'b0;
        bus.vdp_cmd_vram_reading_req = 1'b0;
        bus.mem_rdata = 8'h00;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 4 && bus.DOTSTATE != 2'b00; i++) begin
            tick();
            bus.mem_rdata = 8'h00;
        end
        m_cpu_ack = 1'b0; m_cmd_ack = 1'b0;
        m_cpu_data = 8'h00; m_cmd_data = 8'h00; m_dbi = 8'h00;
        for (int n = 0; n < 40; n++) begin
            logic        we_n, late_cpu, late_cmd;
            logic [18:0] addr, sec_addr;
            logic [7:0]  wdata, rd, rd_sec;
            we_n     = ($urandom_range(0, 3) != 0);
            addr     = 19'($urandom);
            sec_addr = 19'($urandom);
            wdata    = 8'($urandom);
            rd       = 8'($urandom);
            rd_sec   = 8'($urandom);
            late_cpu = ($urandom_range(0, 7) == 0);
            late_cmd = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) bus.VDPVRAMREADINGR = ~bus.VDPVRAMREADINGR;
            if ($urandom_range(0, 2) == 0) bus.vdp_cmd_vram_reading_req = ~bus.vdp_cmd_vram_reading_req;
            if (we_n) begin
                if (bus.VDPVRAMREADINGR != m_cpu_ack) begin
                    m_cpu_ack = bus.VDPVRAMREADINGR; m_cpu_data = rd;
                end else if (bus.vdp_cmd_vram_reading_req != m_cmd_ack) begin
                    m_cmd_ack = bus.vdp_cmd_vram_reading_req; m_cmd_data = rd;
                end
                m_dbi = rd;
            end
            do_dot(we_n, addr, wdata, rd, late_cpu, late_cmd, 1'($urandom), sec_addr, rd_sec);
            n_chk++; if (o_l_addr !== addr) $display("FAIL rnd_addr[%0d]: got %h want %h", n, o_l_addr, addr); else n_pass++;
            n_chk++; if (o_l_we !== we_n || o_l_oe !== ~we_n) $display("FAIL rnd_strobes[%0d]: got we=%b oe=%b want we=%b", n, o_l_we, o_l_oe, we_n); else n_pass++;
            if (!we_n) begin
                n_chk++; if (o_l_wdata !== wdata) $display("FAIL rnd_wdata[%0d]: got %h want %h", n, o_l_wdata, wdata); else n_pass++;
            end
            n_chk++; if (o_c_we !== 1'b1 || o_c_oe !== 1'b1) $display("FAIL rnd_idle[%0d]: got we=%b oe=%b want 1/1", n, o_c_we, o_c_oe); else n_pass++;
            n_chk++; if (o_c_vld !== we_n) $display("FAIL rnd_vld[%0d]: got %b want %b", n, o_c_vld, we_n); else n_pass++;
            n_chk++; if (o_c_dbi !== m_dbi) $display("FAIL rnd_dbi[%0d]: got %h want %h", n, o_c_dbi, m_dbi); else n_pass++;
            n_chk++; if (o_c_cpu_ack !== m_cpu_ack || o_c_cpu_data !== m_cpu_data) $display("FAIL rnd_cpu[%0d]: got %b/%h want %b/%h", n, o_c_cpu_ack, o_c_cpu_data, m_cpu_ack, m_cpu_data); else n_pass++;
            n_chk++; if (o_c_cmd_ack !== m_cmd_ack || o_c_cmd_data !== m_cmd_data) $display("FAIL rnd_cmd[%0d]: got %b/%h want %b/%h", n, o_c_cmd_ack, o_c_cmd_data, m_cmd_ack, m_cmd_data); else n_pass++;
            n_chk++; if (o_s_addr !== sec_addr) $display("FAIL rnd_sec_addr[%0d]: got %h want %h", n, o_s_addr, sec_addr); else n_pass++;
            n_chk++; if (o_s_we !== 1'b1 || o_s_oe !== 1'b0) $display("FAIL rnd_sec_strobes[%0d]: got we=%b oe=%b want 1/0", n, o_s_we, o_s_oe); else n_pass++;
            m_dbi = rd_sec;
            n_chk++; if (o_t_dbi !== m_dbi || o_t_vld !== 1'b1) $display("FAIL rnd_sec_dbi[%0d]: got %h/%b want %h/1", n, o_t_dbi, o_t_vld, m_dbi); else n_pass++;
            n_chk++; if (o_t_cpu_ack !== m_cpu_ack || o_t_cmd_ack !== m_cmd_ack) $display("FAIL rnd_sec_acks[%0d]: got %b/%b want %b/%b", n, o_t_cpu_ack, o_t_cmd_ack, m_cpu_ack, m_cmd_ack); else n_pass++;
        end
    endtask

    initial begin
        bus.DOTSTATE                 = 2'b00;
        bus.IRAMADR                  = 19'h00000;
        bus.PRAMDBO_8                = 8'h00;
        bus.PRAMWE_N                 = 1'b1;
        bus.VDPVRAMREADINGR          = 1'b0;
        bus.vdp_cmd_vram_reading_req = 1'b0;
        bus.mem_rdata                = 8'h00;
        test_reset();
        test_primary_write();
        test_cpu_read();
        test_both_pending();
        test_secondary();
        test_reset_abort();
        test_late_toggle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_access_responder.md
VRAM_ACCESS_RESPONDER -- requirements
Module: vram_access_responder

Interface
REQ-001 CLK21M  in  1  system clock; all state changes on its rising edge.
REQ-002 RESET  in  1  asynchronous, active-high reset.
REQ-003 DOTSTATE  in  2  dot phase, cycling 00->01->11->10->00.
REQ-004 IRAMADR  in  19  VRAM address from the access arbiter.
REQ-005 PRAMDBO_8  in  8  write data from the arbiter; may be Z on reads.
REQ-006 PRAMWE_N  in  1  arbiter write enable, active low.
REQ-007 VDPVRAMREADINGR  in  1  CPU-read toggle request.
REQ-008 vdp_cmd_vram_reading_req  in  1  command-engine read toggle request.
REQ-009 mem_rdata  in  8  external VRAM read data, valid one clock after launch.
REQ-010 mem_addr  out  19  external VRAM address.
REQ-011 mem_wdata  out  8  external VRAM write data.
REQ-012 mem_we_n  out  1  external write strobe, active low.
REQ-013 mem_oe_n  out  1  external read strobe, active low.
REQ-014 PRAMDBI_8  out  8  last captured read data, for the display pipeline.
REQ-015 pramdbi_vld  out  1  one-clock strobe; PRAMDBI_8 was updated this cycle.
REQ-016 VDPVRAMREADINGA  out  1  CPU-read toggle acknowledge.
REQ-017 VDPVRAMRDDATA  out  8  CPU read data.
REQ-018 vdp_cmd_vram_reading_ack  out  1  command read toggle acknowledge.
REQ-019 vdp_cmd_vram_rd_data  out  8  command read data.

Function
REQ-020 Primary slot: launch on a clock with DOTSTATE==00; capture on the next clock (DOTSTATE==01).
REQ-021 Secondary slot: launch on a clock with DOTSTATE==11; capture on the next clock (DOTSTATE==10).
- Secondary slot is read-only.
REQ-022 Launch actions:
- register IRAMADR into mem_addr;
- if write: drive mem_we_n=0 and mem_oe_n=1 for exactly one clock;
- otherwise: drive mem_oe_n=0 and mem_we_n=1 for exactly one clock.
REQ-023 A primary launch with PRAMWE_N==0 is a write.
- Register PRAMDBO_8 into mem_wdata.
- No capture follows; pramdbi_vld stays 0 in the capture cycle.
REQ-024 A secondary launch ignores PRAMWE_N and always reads.
- mem_we_n stays 1 there, even if PRAMWE_N==0.
REQ-025 Every read capture (either slot):
- PRAMDBI_8 <= mem_rdata;
- pramdbi_vld=1 for that one clock.
REQ-026 Tags are latched at a primary read launch:
- cpu_tag = (VDPVRAMREADINGR != VDPVRAMREADINGA);
- cmd_tag = (vdp_cmd_vram_reading_req != vdp_cmd_vram_reading_ack) and not cpu_tag.
REQ-027 At capture with cpu_tag set:
- VDPVRAMRDDATA <= mem_rdata;
- VDPVRAMREADINGA <= the VDPVRAMREADINGR value latched at launch.
REQ-028 At capture with cmd_tag set:
- vdp_cmd_vram_rd_data <= mem_rdata;
- vdp_cmd_vram_reading_ack <= the req value latched at launch.
REQ-029 If both requests are pending at one launch, the CPU read is served first.
- The command read stays pending until the next primary read.
REQ-030 A write launch or a secondary launch never changes any ack or tag.
- Pending requests stay pending.
REQ-031 A request toggle arriving after launch is not served by that slot.
- It is served by the next primary read.
REQ-032 Only the one-clock access pulse is active; all other clocks idle with mem_we_n=1, mem_oe_n=1.
- mem_addr and mem_wdata hold their last values while idle.
REQ-033 Slot state machine: IDLE -> PRI_ACC -> IDLE, and IDLE -> SEC_ACC -> IDLE.
- Each ACC state lasts one clock.
- Capture and acknowledge occur on the clock that leaves the ACC state.
REQ-034 Addresses pass through unmodified in all 19 bits; there is no increment or wrap.

Reset
REQ-035 While RESET=1, outputs take these values:
- mem_addr=19'h7FFFF;
- mem_wdata=0;
- mem_we_n=1, mem_oe_n=1;
- PRAMDBI_8=0, pramdbi_vld=0;
- VDPVRAMRDDATA=0, vdp_cmd_vram_rd_data=0;
- VDPVRAMREADINGA=0, vdp_cmd_vram_reading_ack=0;
- state IDLE, tags cleared.
REQ-036 Reset asserted mid-access aborts the access.
- No capture or acknowledge occurs.
- The first launch after release is the first DOTSTATE==00 or 11 clock.

Verification
REQ-037 Primary write: DOTSTATE=00, IRAMADR=19'h12345, PRAMDBO_8=8'hA5, PRAMWE_N=0.
- Required: mem_addr=12345, mem_wdata=A5, mem_we_n=0 for 1 clock.
- Required: no pramdbi_vld and no ack toggle.
REQ-038 CPU read: VDPVRAMREADINGR=1, READINGA=0, primary read at 19'h00400, mem_rdata=8'h3C.
- Required at DOTSTATE==01: VDPVRAMRDDATA=3C, VDPVRAMREADINGA=1, PRAMDBI_8=3C, pramdbi_vld=1.
REQ-039 CPU and command requests both pending; two primary reads return 11 then 22.
- Required: CPU gets 11 first; command gets 22 and ack toggles one dot cycle later.
REQ-040 Secondary slot with PRAMWE_N=0, mem_rdata=8'h77 at DOTSTATE==11.
- Required: mem_we_n stays 1, mem_oe_n pulses, PRAMDBI_8=77, no ack change.
REQ-041 RESET asserted on the PRI_ACC clock of a pending CPU read.
- Required: VDPVRAMREADINGA stays 0.
- Required: after release, the next primary read serves the request.
REQ-042 Request toggle arriving one clock after the primary launch.
- Required: not acknowledged until the following primary read capture.
